ac_store_ctrl: RTL and testbench

//  Read-side counterpart of the accumulator: on a control-unit STORE, captures AC value + address and

---
 rtl/ccss_pkg.sv | 19 +
 rtl/ac_store_slot.sv | 40 ++++
 rtl/ac_store_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ac_store_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccss_pkg.sv
// Shared definitions for the AC store controller: default widths and FSM state encoding.
package ccss_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StReq  = ST_REQ,
    StDone = ST_DONE,
    StErr  = ST_ERR
  } state_e;

endpackage

// File: rtl/ac_store_slot.sv
// One-deep {addr, data, valid} holding register for a store that arrives while a write is in flight.
module ac_store_slot #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_unload,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Capture on load, free on unload; the owner never loads a full slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_full = r_valid;

endmodule

// File: rtl/ac_store_ctrl.sv
// Accumulator store controller: captures AC value + address on store_en and writes it to data
// memory over a req/ack handshake, with a one-deep pending slot and sticky overrun flag.
// Optional request timeout enabled by defining AC_STORE_TIMEOUT_EN.
module ac_store_ctrl
  import ccss_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              store_en,
  input  logic [DATA_W-1:0] ac_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              err
);

  state_e            r_state;
  logic              r_mem_req;
  logic              r_done;
  logic              r_overrun;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_slot_full;
  logic              w_slot_load;
  logic              w_slot_unload;
  logic              w_finishing;
  logic              w_drop;
  logic [ADDR_W-1:0] w_slot_addr;
  logic [DATA_W-1:0] w_slot_data;

  // DONE and ERR both service the slot on their single cycle.
  assign w_finishing   = (r_state == StDone) || (r_state == StErr);
  assign w_slot_load   = store_en && (r_state == StReq) && !w_slot_full;
  assign w_slot_unload = w_finishing && w_slot_full;
  // A full slot means the new request has nowhere to go, even while the slot is draining.
  assign w_drop        = store_en && w_slot_full && ((r_state == StReq) || w_finishing);

  ac_store_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_slot (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_load   (w_slot_load),
    .i_unload (w_slot_unload),
    .i_addr   (addr_in),
    .i_data   (ac_in),
    .o_addr   (w_slot_addr),
    .o_data   (w_slot_data),
    .o_full   (w_slot_full)
  );

`ifdef AC_STORE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_err;
  logic            w_timeout;

  assign w_timeout = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  // Cycles spent waiting for ack; zero whenever outside REQ so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (reset || (r_state != StReq)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`endif

  // Transfer FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_mem_req <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
`ifdef AC_STORE_TIMEOUT_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef AC_STORE_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (store_en) begin
            r_addr    <= addr_in;
            r_wdata   <= ac_in;
            r_mem_req <= 1'b1;
            r_state   <= StReq;
          end
        end
        StReq: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end
`ifdef AC_STORE_TIMEOUT_EN
          else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= StErr;
          end
`endif
        end
`ifdef AC_STORE_TIMEOUT_EN
        StDone, StErr: begin
`else
        StDone: begin
`endif
          if (w_slot_full) begin
            r_addr    <= w_slot_addr;
            r_wdata   <= w_slot_data;
            r_mem_req <= 1'b1;
            r_state   <= StReq;
          end else if (store_en) begin
            r_addr    <= addr_in;
            r_wdata   <= ac_in;
            r_mem_req <= 1'b1;
            r_state   <= StReq;
          end else begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_req;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != StIdle) || w_slot_full;
  assign done      = r_done;
  assign overrun   = r_overrun;
`ifdef AC_STORE_TIMEOUT_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_ac_store_ctrl.sv
// Self-checking bench for ac_store_ctrl: scoreboard of expected writes, memory responder model.
// Build with AC_STORE_TIMEOUT_EN defined to exercise the timeout path.
module tb_ac_store_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 12;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          store_en;
  logic [DW-1:0] ac_in;
  logic [AW-1:0] addr_in;
  logic          mem_ack = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          overrun;
  logic          err;

  always #5 clk = ~clk;

  ac_store_ctrl #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .store_en  (store_en),
    .ac_in     (ac_in),
    .addr_in   (addr_in),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .err       (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [AW+DW-1:0] exp_q[$];

  // Responder / monitor state (main process never acts on the negative edge).
  bit ack_en     = 1'b0;
  int ack_lat    = 3;
  bit force_ack  = 1'b0;
  bit give_ack   = 1'b0;
  bit prev_req   = 1'b0;
  int wait_cnt   = 0;
  int n_writes   = 0;
  int n_spurious = 0;
  int n_done     = 0;
  int n_err      = 0;
  int req_low    = 0;
  int req_high   = 0;
  int last_gap   = -1;
  int last_high  = 0;
  logic [AW+DW-1:0] exp_w;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder and write monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mem_req) wait_cnt++;
    else wait_cnt = 0;
    give_ack  = force_ack || (ack_en && mem_req && (wait_cnt > ack_lat));
    force_ack = 1'b0;
    if (give_ack && mem_req) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_spurious++;
      end else begin
        exp_w = exp_q.pop_front();
        check_eq("wr addr", 32'(mem_addr), 32'(exp_w[AW+DW-1:DW]));
        check_eq("wr data", 32'(mem_wdata), 32'(exp_w[DW-1:0]));
        check_eq("wr we", 32'(mem_we), 32'd1);
      end
    end
    mem_ack = give_ack;
    if (done) n_done++;
    if (err) n_err++;
    if (mem_req && !prev_req) last_gap = req_low;
    if (mem_req) begin
      req_low = 0;
      req_high++;
    end else begin
      if (prev_req) last_high = req_high;
      req_high = 0;
      req_low++;
    end
    prev_req = mem_req;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit exp_write);
    store_en = 1'b1;
    addr_in  = a;
    ac_in    = d;
    if (exp_write) exp_q.push_back({a, d});
    step();
    store_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    check_eq({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  int d0;
  int nw;

  initial begin
    reset    = 1'b1;
    store_en = 1'b0;
    ac_in    = '0;
    addr_in  = '0;
    step(2);
    reset = 1'b0;
    step();

    // Reset state
    check_eq("rst mem_req", 32'(mem_req), 32'd0);
    check_eq("rst mem_we", 32'(mem_we), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst overrun", 32'(overrun), 32'd0);
    check_eq("rst err", 32'(err), 32'd0);
    check_eq("rst addr", 32'(mem_addr), 32'd0);
    check_eq("rst wdata", 32'(mem_wdata), 32'd0);

    // 1: single store, ack a few cycles after req
    ack_en  = 1'b1;
    ack_lat = 3;
    d0      = n_done;
    store(12'h040, 16'hBEEF, 1'b1);
    check_eq("t1 req up", 32'(mem_req), 32'd1);
    for (int k = 0; k < 20 && done !== 1'b1; k++) step();
    check_eq("t1 done seen", 32'(done), 32'd1);
    check_eq("t1 busy in done", 32'(busy), 32'd1);
    step();
    check_eq("t1 busy after", 32'(busy), 32'd0);
    check_eq("t1 done pulse", 32'(done), 32'd0);
    check_eq("t1 done count", 32'(n_done - d0), 32'd1);
    check_eq("t1 q empty", 32'(exp_q.size()), 32'd0);

    // 2: back-to-back, second lands in slot
    d0 = n_done;
    store(12'h001, 16'hA5A5, 1'b1);
    step();
    store(12'h002, 16'h5A5A, 1'b1);
    wait_idle("t2", 40);
    check_eq("t2 done count", 32'(n_done - d0), 32'd2);
    check_eq("t2 q empty", 32'(exp_q.size()), 32'd0);
    check_eq("t2 overrun", 32'(overrun), 32'd0);
    check_eq("t2 req gap", 32'(last_gap), 32'd1);

    // ack and store on the same edge: both honoured
    ack_en = 1'b0;
    d0     = n_done;
    store(12'h010, 16'h1111, 1'b1);
    step(2);
    force_ack = 1'b1;
    store(12'h011, 16'h2222, 1'b1);
    check_eq("sim done", 32'(done), 32'd1);
    ack_en = 1'b1;
    wait_idle("sim", 40);
    check_eq("sim done count", 32'(n_done - d0), 32'd2);
    check_eq("sim q empty", 32'(exp_q.size()), 32'd0);
    check_eq("sim overrun", 32'(overrun), 32'd0);

    // stray ack while idle is ignored
    d0        = n_done;
    nw        = n_writes;
    force_ack = 1'b1;
    step(3);
    check_eq("stray req", 32'(mem_req), 32'd0);
    check_eq("stray busy", 32'(busy), 32'd0);
    check_eq("stray done", 32'(n_done - d0), 32'd0);
    check_eq("stray writes", 32'(n_writes - nw), 32'd0);

    // 3: overrun
    ack_en = 1'b0;
    d0     = n_done;
    store(12'h100, 16'h0001, 1'b1);
    store(12'h101, 16'h0002, 1'b1);
    check_eq("t3 no ovr yet", 32'(overrun), 32'd0);
    store(12'h102, 16'h0003, 1'b0);
    check_eq("t3 overrun", 32'(overrun), 32'd1);
    check_eq("t3 addr held", 32'(mem_addr), 32'h100);
    ack_en = 1'b1;
    wait_idle("t3", 40);
    check_eq("t3 done count", 32'(n_done - d0), 32'd2);
    check_eq("t3 q empty", 32'(exp_q.size()), 32'd0);
    check_eq("t3 overrun sticky", 32'(overrun), 32'd1);

    // 4: data stability while stalled
    ack_en = 1'b0;
    store(12'h0AA, 16'h1234, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ac_in   = DW'($urandom);
      addr_in = AW'($urandom);
      step();
      check_eq("t4 wdata", 32'(mem_wdata), 32'h1234);
      check_eq("t4 addr", 32'(mem_addr), 32'h0AA);
    end
    ack_en = 1'b1;
    wait_idle("t4", 40);
    check_eq("t4 q empty", 32'(exp_q.size()), 32'd0);

    // 5: reset mid-REQ with slot full
    ack_en = 1'b0;
    store(12'h200, 16'hAAAA, 1'b0);
    store(12'h201, 16'hBBBB, 1'b0);
    check_eq("t5 req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t5 req", 32'(mem_req), 32'd0);
    check_eq("t5 busy", 32'(busy), 32'd0);
    check_eq("t5 overrun", 32'(overrun), 32'd0);
    nw     = n_writes;
    ack_en = 1'b1;
    step(10);
    check_eq("t5 no writes", 32'(n_writes - nw), 32'd0);
    check_eq("t5 req idle", 32'(mem_req), 32'd0);

    // 6: timeout behaviour
    ack_en = 1'b0;
    d0     = n_done;
    nw     = n_err;
    store(12'h300, 16'hCAFE, 1'b0);
`ifdef AC_STORE_TIMEOUT_EN
    step(12);
    check_eq("t6 req dropped", 32'(mem_req), 32'd0);
    check_eq("t6 req cycles", 32'(last_high), 32'(TO));
    check_eq("t6 err pulses", 32'(n_err - nw), 32'd1);
    check_eq("t6 done none", 32'(n_done - d0), 32'd0);
    check_eq("t6 busy", 32'(busy), 32'd0);
`else
    step(40);
    check_eq("t6 req held", 32'(mem_req), 32'd1);
    check_eq("t6 req run", 32'(req_high >= 40), 32'd1);
    check_eq("t6 err none", 32'(n_err - nw), 32'd0);
    check_eq("t6 done none", 32'(n_done - d0), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif

    check_eq("final q empty", 32'(exp_q.size()), 32'd0);
    check_eq("spurious writes", 32'(n_spurious), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
